// File: rtl/coherence_req_arbiter.sv
// rtl/coherence_req_arbiter.sv - round-robin serializer of L1 coherence requests onto the snoop bus

package cache_types;
  localparam int NUM_CACHE = 8;
  localparam int ADDR_W    = 32;
  localparam int SRC_W     = 4;

  // IDLE is encoded as zero so an all-zero bus reads as "no transaction"
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    GETS = 3'd1,
    GETM = 3'd2,
    PUTM = 3'd3,
    PUTS = 3'd4
  } bus_tx_t;

  typedef struct packed {
    logic              valid;
    bus_tx_t           bus_tx;
    logic [ADDR_W-1:0] addr;
    logic [SRC_W-1:0]  source;
  } req_msg_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [SRC_W-1:0]  destination;
    logic              memory_flag;
  } resp_msg_t;
endpackage

module coherence_req_arbiter #(
  parameter int NUM_REQ = cache_types::NUM_CACHE,
  parameter int TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  cache_types::req_msg_t   req_i [NUM_REQ],
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  cache_types::resp_msg_t  resp_i,
  output cache_types::req_msg_t   bus_o,
  output logic [$clog2(NUM_REQ):0] grant_id_o,
  output logic                    busy_o,
  output logic                    timeout_o
);
  import cache_types::*;

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GW = $clog2(NUM_REQ) + 1;
  localparam int WW = $clog2(TIMEOUT) + 1;
  localparam int SW = SRC_W;

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_BCAST = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t        r_state;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] r_owner;
  logic [WW-1:0] r_wd;
  req_msg_t      r_bus;
  logic          r_timeout;

  logic          w_found;
  logic [PW-1:0] w_winner;
  req_msg_t      w_sel_msg;
  logic          w_accept;
  logic          w_addr_hit;
  logic          w_match;
  logic          w_complete;
  logic          w_expire;

  // advance a requester index by one with wrap at NUM_REQ-1
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(NUM_REQ - 1)) return '0;
    return p + PW'(1);
  endfunction

  // round-robin scan starting at r_ptr; the first valid requester wins
  always_comb begin
    int            idx;
    logic [PW-1:0] w_idx;
    w_found  = 1'b0;
    w_winner = r_ptr;
    idx      = 0;
    w_idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(r_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      w_idx = idx[PW-1:0];
      if (!w_found && req_i[w_idx].valid) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  assign w_accept = (r_state == ST_ARB) && w_found;

  // selected message with source replaced by the winning index
  always_comb begin
    w_sel_msg        = req_i[w_winner];
    w_sel_msg.source = SW'(w_winner);
  end

  // one-hot accept pulse, only ever raised while arbitrating
  always_comb begin
    req_ready_o = '0;
    if (w_accept) req_ready_o[w_winner] = 1'b1;
  end

  // completion match: address always, plus destination or memory ack by type
  always_comb begin
    w_addr_hit = resp_i.valid && (resp_i.addr == r_bus.addr);
    w_match    = w_addr_hit;
    case (r_bus.bus_tx)
      GETS, GETM: w_match = w_addr_hit && (resp_i.destination == r_bus.source);
      PUTM:       w_match = w_addr_hit && resp_i.memory_flag;
      default:    w_match = w_addr_hit;
    endcase
  end

  assign w_complete = (r_state == ST_WAIT) && w_match;
  assign w_expire   = (r_state == ST_WAIT) && !w_match && (r_wd == WW'(TIMEOUT - 1));

  // arbitration / broadcast / wait-for-response sequencer with watchdog
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_ARB;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_wd      <= '0;
      r_bus     <= '0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_ARB: begin
          if (w_accept) begin
            if (w_sel_msg.bus_tx == IDLE) begin
              r_ptr <= ptr_inc(w_winner);
            end else begin
              r_owner <= w_winner;
              r_bus   <= w_sel_msg;
              r_state <= ST_BCAST;
            end
          end
        end
        ST_BCAST: begin
          r_bus.valid <= 1'b0;
          r_wd        <= '0;
          r_state     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_complete) begin
            r_ptr   <= ptr_inc(r_owner);
            r_state <= ST_ARB;
          end else if (w_expire) begin
            r_timeout <= 1'b1;
            r_ptr     <= ptr_inc(r_owner);
            r_state   <= ST_ARB;
          end else begin
            r_wd <= r_wd + WW'(1);
          end
        end
        default: r_state <= ST_ARB;
      endcase
    end
  end

  assign bus_o      = r_bus;
  assign busy_o     = w_accept || (r_state != ST_ARB);
  assign grant_id_o = w_accept ? GW'(w_winner) : GW'(r_owner);
  assign timeout_o  = r_timeout;

endmodule

// File: tb/tb_coherence_req_arbiter.sv
// tb/tb_coherence_req_arbiter.sv - table-driven and directed checks for coherence_req_arbiter
module tb_coherence_req_arbiter;
  import cache_types::*;

  logic       clk;
  logic       rst_n;
  req_msg_t   req [8];
  logic [7:0] req_ready;
  resp_msg_t  resp;
  req_msg_t   bus;
  logic [3:0] grant_id;
  logic       busy;
  logic       tmo;

  int n_checks = 0;
  int n_errors = 0;

  coherence_req_arbiter #(.NUM_REQ(8), .TIMEOUT(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req),
    .req_ready_o (req_ready),
    .resp_i      (resp),
    .bus_o       (bus),
    .grant_id_o  (grant_id),
    .busy_o      (busy),
    .timeout_o   (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [7:0]  req_v;
    bus_tx_t     tx;
    logic [31:0] addr;
    logic        rv;
    logic [31:0] raddr;
    logic [3:0]  rdst;
    logic        rmf;
    logic [7:0]  e_ready;
    logic        e_bv;
    logic [3:0]  e_src;
    logic        e_busy;
    logic [3:0]  e_grant;
    logic        e_tmo;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [7:0] m, input bus_tx_t tx, input logic [31:0] a,
                     input logic rv, input logic [31:0] ra, input logic [3:0] rd, input logic rm,
                     input logic [7:0] er, input logic ebv, input logic [3:0] es, input logic eb,
                     input logic [3:0] eg, input logic et, input string nm);
    vec_t v;
    v.rst_n = r; v.req_v = m; v.tx = tx; v.addr = a;
    v.rv = rv; v.raddr = ra; v.rdst = rd; v.rmf = rm;
    v.e_ready = er; v.e_bv = ebv; v.e_src = es; v.e_busy = eb; v.e_grant = eg; v.e_tmo = et;
    v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // source is preloaded with garbage so the overwrite by the arbiter is visible
  task automatic apply(input logic r, input logic [7:0] m, input bus_tx_t tx, input logic [31:0] a,
                       input logic rv, input logic [31:0] ra, input logic [3:0] rd, input logic rm);
    @(negedge clk);
    rst_n = r;
    for (int k = 0; k < 8; k++) begin
      req[k].valid  = m[k];
      req[k].bus_tx = tx;
      req[k].addr   = a;
      req[k].source = 4'hF;
    end
    resp.valid       = rv;
    resp.addr        = ra;
    resp.destination = rd;
    resp.memory_flag = rm;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 8; k++) req[k] = '0;
    resp = '0;

    //   rst req  tx    addr   rv raddr  dst mf  ready bv src busy grant tmo
    add(0, 8'h00, IDLE, 32'h0,   0, 32'h0,   0, 0, 8'h00, 0, 0, 0, 0, 0, "reset0");
    add(0, 8'h00, IDLE, 32'h0,   0, 32'h0,   0, 0, 8'h00, 0, 0, 0, 0, 0, "reset1");
    add(1, 8'h08, GETS, 32'h100, 0, 32'h0,   0, 0, 8'h08, 0, 0, 1, 3, 0, "acc3");
    add(1, 8'h00, IDLE, 32'h0,   0, 32'h0,   0, 0, 8'h00, 1, 3, 1, 3, 0, "bcast3");
    add(1, 8'h00, IDLE, 32'h0,   1, 32'h104, 3, 0, 8'h00, 0, 0, 1, 3, 0, "bad_addr");
    add(1, 8'h00, IDLE, 32'h0,   1, 32'h100, 2, 0, 8'h00, 0, 0, 1, 3, 0, "bad_dst");
    add(1, 8'h00, IDLE, 32'h0,   1, 32'h100, 3, 0, 8'h00, 0, 0, 1, 3, 0, "done3");
    add(1, 8'h20, IDLE, 32'h0,   0, 32'h0,   0, 0, 8'h20, 0, 0, 1, 5, 0, "idle5");
    add(1, 8'h21, GETM, 32'h200, 0, 32'h0,   0, 0, 8'h01, 0, 0, 1, 0, 0, "ptr6_wrap");
    add(1, 8'h20, GETM, 32'h200, 0, 32'h0,   0, 0, 8'h00, 1, 0, 1, 0, 0, "bcast0");
    add(1, 8'h20, GETM, 32'h200, 1, 32'h200, 0, 0, 8'h00, 0, 0, 1, 0, 0, "done0");
    add(1, 8'h20, GETM, 32'h200, 0, 32'h0,   0, 0, 8'h20, 0, 0, 1, 5, 0, "acc5");
    add(1, 8'h00, IDLE, 32'h0,   0, 32'h0,   0, 0, 8'h00, 1, 5, 1, 5, 0, "bcast5");
    add(1, 8'h00, IDLE, 32'h0,   1, 32'h200, 5, 0, 8'h00, 0, 0, 1, 5, 0, "done5");
    add(1, 8'h00, IDLE, 32'h0,   0, 32'h0,   0, 0, 8'h00, 0, 0, 0, 0, 0, "idle_after");

    foreach (vecs[i]) begin
      apply(vecs[i].rst_n, vecs[i].req_v, vecs[i].tx, vecs[i].addr,
            vecs[i].rv, vecs[i].raddr, vecs[i].rdst, vecs[i].rmf);
      chk({vecs[i].name, ".ready"}, 64'(req_ready), 64'(vecs[i].e_ready));
      chk({vecs[i].name, ".bus_valid"}, 64'(bus.valid), 64'(vecs[i].e_bv));
      chk({vecs[i].name, ".busy"}, 64'(busy), 64'(vecs[i].e_busy));
      chk({vecs[i].name, ".timeout"}, 64'(tmo), 64'(vecs[i].e_tmo));
      if (vecs[i].e_bv) chk({vecs[i].name, ".source"}, 64'(bus.source), 64'(vecs[i].e_src));
      if (vecs[i].e_busy) chk({vecs[i].name, ".grant"}, 64'(grant_id), 64'(vecs[i].e_grant));
      if (!vecs[i].rst_n) begin
        chk({vecs[i].name, ".bus_zero"}, 64'(bus), 64'h0);
        chk({vecs[i].name, ".grant_zero"}, 64'(grant_id), 64'h0);
      end
    end

    // fairness: every cache holds GETM from reset; grants go 0..7 then 0
    apply(0, 8'h00, IDLE, 32'h0, 0, 32'h0, 0, 0);
    apply(0, 8'h00, IDLE, 32'h0, 0, 32'h0, 0, 0);
    for (int n = 0; n < 9; n++) begin
      logic [3:0] g;
      g = 4'(n % 8);
      apply(1, 8'hFF, GETM, 32'h300, 0, 32'h0, 0, 0);
      chk("fair.ready", 64'(req_ready), 64'(8'h01 << g));
      chk("fair.grant", 64'(grant_id), 64'(g));
      apply(1, 8'hFF, GETM, 32'h300, 0, 32'h0, 0, 0);
      chk("fair.bcast", 64'({bus.valid, bus.source, req_ready}), 64'({1'b1, g, 8'h00}));
      apply(1, 8'hFF, GETM, 32'h300, 1, 32'h300, g, 0);
      chk("fair.wait", 64'({bus.valid, busy, req_ready}), 64'({1'b0, 1'b1, 8'h00}));
    end

    // PUTM needs the memory acknowledgement, destination alone is not enough
    apply(1, 8'h04, PUTM, 32'h40, 0, 32'h0, 0, 0);
    chk("putm.ready", 64'(req_ready), 64'h04);
    apply(1, 8'h00, IDLE, 32'h0, 0, 32'h0, 0, 0);
    chk("putm.bcast", 64'({bus.valid, bus.source, bus.bus_tx}), 64'({1'b1, 4'd2, PUTM}));
    apply(1, 8'h00, IDLE, 32'h0, 1, 32'h40, 2, 0);
    chk("putm.nomf", 64'(busy), 64'h1);
    apply(1, 8'h00, IDLE, 32'h0, 1, 32'h40, 2, 1);
    chk("putm.still", 64'(busy), 64'h1);
    apply(1, 8'h00, IDLE, 32'h0, 0, 32'h0, 0, 0);
    chk("putm.done", 64'(busy), 64'h0);

    // watchdog: no response for cache 4, cache 6 waits behind it
    apply(1, 8'h10, GETS, 32'h500, 0, 32'h0, 0, 0);
    chk("wd.acc", 64'(req_ready), 64'h10);
    apply(1, 8'h40, GETS, 32'h600, 0, 32'h0, 0, 0);
    chk("wd.bcast", 64'({bus.valid, bus.source}), 64'({1'b1, 4'd4}));
    for (int i = 0; i < 16; i++) begin
      apply(1, 8'h40, GETS, 32'h600, 0, 32'h0, 0, 0);
      chk("wd.wait", 64'({tmo, busy, req_ready}), 64'({1'b0, 1'b1, 8'h00}));
    end
    apply(1, 8'h40, GETS, 32'h600, 0, 32'h0, 0, 0);
    chk("wd.tmo", 64'(tmo), 64'h1);
    chk("wd.next", 64'({req_ready, grant_id}), 64'({8'h40, 4'd6}));
    apply(1, 8'h00, IDLE, 32'h0, 0, 32'h0, 0, 0);
    chk("wd.sticky", 64'({tmo, bus.valid, bus.source}), 64'({1'b1, 1'b1, 4'd6}));
    apply(1, 8'h00, IDLE, 32'h0, 0, 32'h0, 0, 0);

    // reset while waiting for the response drops the transaction
    apply(0, 8'h00, IDLE, 32'h0, 0, 32'h0, 0, 0);
    apply(1, 8'h00, IDLE, 32'h0, 0, 32'h0, 0, 0);
    chk("rst.outs", 64'({tmo, busy, req_ready, grant_id}), 64'h0);
    chk("rst.bus", 64'(bus), 64'h0);
    apply(1, 8'h81, GETS, 32'h700, 0, 32'h0, 0, 0);
    chk("rst.first", 64'({req_ready, grant_id}), 64'({8'h01, 4'd0}));
    apply(1, 8'h00, IDLE, 32'h0, 0, 32'h0, 0, 0);
    chk("rst.bcast", 64'({bus.valid, bus.source, bus.addr}), 64'({1'b1, 4'd0, 32'h700}));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
